grid_game_ctrl: RTL and testbench

Parametrised successor to the fixed 3x3 game controller: it runs the hazard/gold/life game over a configurable grid of CELLS box switches. Each round has a warning phase then a fire phase, with pseudo-random hazard placement, gold pickup, saturating score and a configurable life count. It sits between the debounced start pulse and switch inputs and the display controller, and runs entirely in the 25 MHz pixel domain. A one-cycle `tick` strobe replaces the old divided clocks.

---
 rtl/grid_game_pkg.sv | 31 +++
 rtl/grid_lfsr16.sv | 28 ++
 rtl/grid_game_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_grid_game_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_game_pkg.sv
// grid_game_pkg: shared encodings for the grid hazard/gold/life game.
//   - game_state output codes (IDLE/PLAY/OVER)
//   - internal FSM state enum
//   - LFSR seed and tap mask for the 16-bit Fibonacci generator
//   - helper mapping an FSM state onto its reported game_state code
package grid_game_pkg;

  localparam logic [1:0] GS_IDLE = 2'd0;
  localparam logic [1:0] GS_PLAY = 2'd1;
  localparam logic [1:0] GS_OVER = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARN = 2'd1,
    ST_FIRE = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] game_state_of(input state_e s);
    case (s)
      ST_WARN, ST_FIRE: return GS_PLAY;
      ST_OVER:          return GS_OVER;
      default:          return GS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/grid_lfsr16.sv
// grid_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
// Advances every clock regardless of game activity so that the moment a
// player presses start randomises the round layout.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset, loads LFSR_SEED
//   lfsr_o  current register value
module grid_lfsr16
  import grid_game_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/grid_game_ctrl.sv
// grid_game_ctrl: hazard/gold/life game over a grid of CELLS box switches.
// Each round shows a warning mask, then turns it into a fire mask; players
// standing on fire lose at most one life per round, players reaching the
// gold cell score (saturating). All outputs are registered.
// Optional feature macro: SUPER_IMMUNITY_EN -- when defined, super_i=1
// makes hits harmless; otherwise super_i is ignored.
// Ports:
//   clk_i            25 MHz pixel clock
//   rst_ni           synchronous active-low reset
//   tick_i           one-cycle game-rate enable
//   start_i          one-pulse start request
//   super_i          immunity request
//   box_i            player occupancy per cell
//   game_state_o     0 IDLE, 1 PLAY, 2 OVER
//   score_o          gold collected, saturating
//   warning_state_o  cells about to ignite
//   fire_state_o     burning cells
//   gold_state_o     one-hot gold cell or 0
//   life_o           lives remaining
module grid_game_ctrl
  import grid_game_pkg::*;
#(
  parameter int CELLS      = 9,
  parameter int SCORE_W    = 4,
  parameter int LIFE_W     = 2,
  parameter int MAX_LIFE   = 3,
  parameter int WARN_TICKS = 4,
  parameter int FIRE_TICKS = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               super_i,
  input  logic [CELLS-1:0]   box_i,
  output logic [1:0]         game_state_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [CELLS-1:0]   warning_state_o,
  output logic [CELLS-1:0]   fire_state_o,
  output logic [CELLS-1:0]   gold_state_o,
  output logic [LIFE_W-1:0]  life_o
);

  localparam int TMAX    = (WARN_TICKS > FIRE_TICKS) ? WARN_TICKS : FIRE_TICKS;
  localparam int TIMER_W = $clog2(TMAX + 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [15:0] lfsr;

  grid_lfsr16 u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lfsr_o (lfsr)
  );

  state_e             state_q, state_d;
  logic [1:0]         game_state_q, game_state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIFE_W-1:0]  life_q, life_d;
  logic [CELLS-1:0]   warn_q, warn_d;
  logic [CELLS-1:0]   fire_q, fire_d;
  logic [CELLS-1:0]   gold_q, gold_d;
  logic               hit_q, hit_d;

  logic               immune;
  logic               unused_lfsr_bits;

  assign unused_lfsr_bits = ^lfsr;

`ifdef SUPER_IMMUNITY_EN
  assign immune = super_i;
`else
  logic unused_super;
  assign unused_super = super_i;
  assign immune       = 1'b0;
`endif

  // Round layout derived from the current LFSR value.
  logic [CELLS-1:0] load_warn;
  logic [CELLS-1:0] load_gold;
  logic [CELLS-1:0] gold_oh;
  logic [4:0]       gold_idx;

  always_comb begin
    load_warn = lfsr[CELLS-1:0];
    if (load_warn == '0) load_warn = {{(CELLS-1){1'b0}}, 1'b1};
    // Index is 0..15 and CELLS >= 8, so one subtraction folds it into range.
    gold_idx = {1'b0, lfsr[15:12]};
    if (gold_idx >= 5'(CELLS)) gold_idx = gold_idx - 5'(CELLS);
    gold_oh   = {{(CELLS-1){1'b0}}, 1'b1} << gold_idx;
    load_gold = ((gold_oh & load_warn) != '0) ? '0 : gold_oh;
  end

  logic gold_hit;
  logic life_loss;
  logic last_tick;

  assign gold_hit  = |(box_i & gold_q);
  // Only the first effective hit of a round costs a life.
  assign life_loss = (state_q == ST_FIRE) && |(box_i & fire_q) && !immune && !hit_q;
  assign last_tick = (timer_q == TIMER_W'(1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    score_d = score_q;
    life_d  = life_q;
    warn_d  = warn_q;
    fire_d  = fire_q;
    gold_d  = gold_q;
    hit_d   = hit_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          score_d = '0;
          life_d  = LIFE_W'(MAX_LIFE);
          warn_d  = load_warn;
          gold_d  = load_gold;
          fire_d  = '0;
          hit_d   = 1'b0;
          timer_d = TIMER_W'(WARN_TICKS);
          state_d = ST_WARN;
        end
      end
      ST_WARN, ST_FIRE: begin
        if (tick_i) begin
          if (gold_hit) begin
            score_d = sat_inc(score_q);
            gold_d  = '0;
          end
          if (life_loss) begin
            life_d = life_q - 1'b1;
            hit_d  = 1'b1;
          end
          timer_d = timer_q - 1'b1;
          // Losing the last life overrides the phase transition.
          if (life_loss && (life_q == LIFE_W'(1))) begin
            warn_d  = '0;
            fire_d  = '0;
            gold_d  = '0;
            state_d = ST_OVER;
          end else if (last_tick) begin
            if (state_q == ST_WARN) begin
              fire_d  = warn_q;
              warn_d  = '0;
              timer_d = TIMER_W'(FIRE_TICKS);
              state_d = ST_FIRE;
            end else begin
              fire_d  = '0;
              warn_d  = load_warn;
              gold_d  = load_gold;
              hit_d   = 1'b0;
              timer_d = TIMER_W'(WARN_TICKS);
              state_d = ST_WARN;
            end
          end
        end
      end
      ST_OVER: begin
        if (start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    game_state_d = game_state_of(state_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      game_state_q <= GS_IDLE;
      timer_q      <= '0;
      score_q      <= '0;
      life_q       <= LIFE_W'(MAX_LIFE);
      warn_q       <= '0;
      fire_q       <= '0;
      gold_q       <= '0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_state_q <= game_state_d;
      timer_q      <= timer_d;
      score_q      <= score_d;
      life_q       <= life_d;
      warn_q       <= warn_d;
      fire_q       <= fire_d;
      gold_q       <= gold_d;
      hit_q        <= hit_d;
    end
  end

  assign game_state_o    = game_state_q;
  assign score_o         = score_q;
  assign warning_state_o = warn_q;
  assign fire_state_o    = fire_q;
  assign gold_state_o    = gold_q;
  assign life_o          = life_q;

endmodule

// File: tb/tb_grid_game_ctrl.sv
// Self-checking bench for grid_game_ctrl: a behavioural game model tracks
// the expected outputs every cycle while directed steps exercise start,
// round timing, gold pickup, score saturation, life loss and reset.
module tb_grid_game_ctrl;

  localparam int CELLS = 9;
  localparam int MAXL  = 3;
  localparam int WT    = 4;
  localparam int FT    = 2;
  localparam int P_IDLE = 0, P_WARN = 1, P_FIRE = 2, P_OVER = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, tick, start, sup;
  logic [CELLS-1:0] box;

  logic [1:0]       gs_a, gs_b;
  logic [3:0]       score_a;
  logic [1:0]       score_b;
  logic [CELLS-1:0] warn_a, fire_a, gold_a, warn_b, fire_b, gold_b;
  logic [1:0]       life_a, life_b;

  grid_game_ctrl u_dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_i(start), .super_i(sup),
    .box_i(box), .game_state_o(gs_a), .score_o(score_a), .warning_state_o(warn_a),
    .fire_state_o(fire_a), .gold_state_o(gold_a), .life_o(life_a)
  );

  grid_game_ctrl #(.SCORE_W(2)) u_dut_w2 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_i(start), .super_i(sup),
    .box_i(box), .game_state_o(gs_b), .score_o(score_b), .warning_state_o(warn_b),
    .fire_state_o(fire_b), .gold_state_o(gold_b), .life_o(life_b)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int pol = 0;
  bit timeout_seen = 0;

  // Reference model state
  logic [15:0]      m_lfsr;
  int               m_phase, m_left, m_score, m_score2, m_life;
  logic [CELLS-1:0] m_warn, m_fire, m_gold;
  bit               m_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int satv(input int v, input int w);
    return (v >= (1 << w) - 1) ? (1 << w) - 1 : v + 1;
  endfunction

  function automatic int gs_of(input int p);
    return (p == P_IDLE) ? 0 : (p == P_OVER) ? 2 : 1;
  endfunction

  task automatic load_round(input logic [15:0] v);
    int g;
    m_warn = v[CELLS-1:0];
    if (m_warn == 0) m_warn = 9'd1;
    g = int'(v[15:12]);
    if (g >= CELLS) g = g - CELLS;
    m_gold = m_warn[g] ? 9'd0 : 9'(1 << g);
    m_hit  = 0;
  endtask

  task automatic model_update();
    logic [15:0] cur;
    bit gh, hit, immune;
    cur = m_lfsr;
    if (!rst_n) begin
      m_lfsr = 16'hACE1; m_phase = P_IDLE; m_left = 0; m_score = 0; m_score2 = 0;
      m_life = MAXL; m_warn = 0; m_fire = 0; m_gold = 0; m_hit = 0;
      return;
    end
    m_lfsr = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    immune = 0;
`ifdef SUPER_IMMUNITY_EN
    immune = sup;
`endif
    case (m_phase)
      P_IDLE: if (start) begin
        m_score = 0; m_score2 = 0; m_life = MAXL; m_fire = 0;
        load_round(cur); m_phase = P_WARN; m_left = WT;
      end
      P_WARN, P_FIRE: if (tick) begin
        gh  = (box & m_gold) != 0;
        hit = (m_phase == P_FIRE) && ((box & m_fire) != 0) && !immune && !m_hit;
        if (gh) begin
          m_score = satv(m_score, 4); m_score2 = satv(m_score2, 2); m_gold = 0;
        end
        if (hit) begin m_life--; m_hit = 1; end
        m_left--;
        if (m_life == 0) begin
          m_warn = 0; m_fire = 0; m_gold = 0; m_phase = P_OVER;
        end else if (m_left == 0) begin
          if (m_phase == P_WARN) begin
            m_fire = m_warn; m_warn = 0; m_phase = P_FIRE; m_left = FT;
          end else begin
            m_fire = 0; load_round(cur); m_phase = P_WARN; m_left = WT;
          end
        end
      end
      P_OVER: if (start) m_phase = P_IDLE;
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("game_state", 32'(gs_a), gs_of(m_phase));
    chk("score", 32'(score_a), m_score);
    chk("life", 32'(life_a), m_life);
    chk("warning_state", 32'(warn_a), 32'(m_warn));
    chk("fire_state", 32'(fire_a), 32'(m_fire));
    chk("gold_state", 32'(gold_a), 32'(m_gold));
    chk("score_w2", 32'(score_b), m_score2);
    chk("life_w2", 32'(life_b), m_life);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  // Random idle gap (with ignored start pulses), then one tick cycle.
  task automatic do_tick();
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      start = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 0;
    case (pol)
      0: box = '0;
      1: box = '1;
      2: begin
        box = CELLS'($urandom);
        if (m_phase == P_FIRE) box = box & ~m_fire;
      end
      3: box = m_gold;
      default: ;
    endcase
    tick = 1;
    step();
    tick = 0;
  endtask

  task automatic run_round();
    int g;
    g = 0;
    while (m_phase == P_WARN && g < 40) begin do_tick(); g++; end
    while (m_phase == P_FIRE && g < 40) begin do_tick(); g++; end
    if (g >= 40) timeout_seen = 1;
  endtask

  initial begin
    logic [CELLS-1:0] w;
    int sc;
    bit found;

    rst_n = 0; tick = 0; start = 0; sup = 0; box = '0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_game_state", 32'(gs_a), 0);
    chk("rst_life", 32'(life_a), MAXL);
    chk("rst_masks", 32'(warn_a | fire_a | gold_a), 0);

    // Wait for an LFSR value with all mask bits zero, then start with a tick.
    rst_n = 1;
    found = 0;
    for (int i = 0; i < 66000; i++) begin
      if (m_lfsr[CELLS-1:0] == 0) begin found = 1; break; end
      step();
    end
    chk("zero_mask_found", 32'(found), 1);
    start = 1; tick = 1;
    step();
    start = 0; tick = 0;
    chk("zero_mask_warn", 32'(warn_a), 32'h1);
    chk("start_tick_gs", 32'(gs_a), 1);

    // Four ticks of warning, then two of fire.
    w = m_warn;
    pol = 0;
    for (int i = 0; i < WT; i++) do_tick();
    chk("fire_from_warn", 32'(fire_a), 32'(w));
    chk("warn_cleared", 32'(warn_a), 0);
    for (int i = 0; i < FT; i++) do_tick();
    chk("new_round_gs", 32'(gs_a), 1);
    chk("new_round_fire0", 32'(fire_a), 0);
    chk("new_round_warn", 32'(warn_a != 0), 1);

    // Directed gold pickup, second tick on the same cell must not score.
    found = 0;
    for (int r = 0; r < 60 && !found; r++) begin
      if (m_gold != 0) begin
        found = 1;
        sc  = m_score;
        box = m_gold;
        pol = 4;
        do_tick();
        chk("gold_score", 32'(score_a), sc + 1);
        chk("gold_cleared", 32'(gold_a), 0);
        do_tick();
        chk("gold_once", 32'(score_a), sc + 1);
        pol = 0;
      end
      run_round();
    end
    chk("gold_round_found", 32'(found), 1);

    // Randomised play avoiding fire cells.
    pol = 2;
    for (int r = 0; r < 20; r++) run_round();

    // Keep collecting gold until the narrow score must saturate.
    pol = 3;
    for (int r = 0; r < 300 && m_score < 5; r++) run_round();
    chk("sat_w2", 32'(score_b), 3);
    chk("score_w4_ge5", 32'(score_a >= 5), 1);

    // Drop to one life, then hit and collect gold on the same tick.
    pol = 1;
    run_round();
    run_round();
    chk("life_at_one", 32'(life_a), 1);
    found = 0;
    for (int r = 0; r < 100 && !found; r++) begin
      pol = 0;
      while (m_phase == P_WARN) do_tick();
      if (m_phase == P_FIRE && m_gold != 0) begin
        found = 1;
        sc  = m_score;
        box = m_fire | m_gold;
        pol = 4;
        do_tick();
        chk("hg_life", 32'(life_a), 0);
        chk("hg_score", 32'(score_a), satv(sc, 4));
        chk("hg_over", 32'(gs_a), 2);
        chk("hg_masks", 32'(warn_a | fire_a | gold_a), 0);
      end else begin
        while (m_phase == P_FIRE) do_tick();
      end
    end
    chk("hg_found", 32'(found), 1);

    pol = 0; box = '0;
    start = 1; step(); start = 0;
    chk("over_to_idle", 32'(gs_a), 0);

    // Reset in the middle of a round.
    start = 1; step(); start = 0;
    do_tick();
    do_tick();
    rst_n = 0; step();
    chk("midrst_gs", 32'(gs_a), 0);
    chk("midrst_life", 32'(life_a), MAXL);
    chk("midrst_masks", 32'(warn_a | fire_a | gold_a), 0);
    rst_n = 1; step();

    // Standing everywhere: one life lost per round until game over.
    start = 1; step(); start = 0;
    pol = 1; sup = 0;
    for (int r = 0; r < 3; r++) begin
      run_round();
      chk("drain_life", 32'(life_a), MAXL - 1 - r);
    end
    chk("drain_gs", 32'(gs_a), 2);
    chk("drain_masks", 32'(warn_a | fire_a | gold_a), 0);

    // Immunity request while standing everywhere.
    box = '0;
    start = 1; step(); start = 0;
    start = 1; step(); start = 0;
    sup = 1; pol = 1;
    for (int r = 0; r < 3; r++) run_round();
`ifdef SUPER_IMMUNITY_EN
    chk("super_life", 32'(life_a), MAXL);
    chk("super_gs", 32'(gs_a), 1);
`else
    chk("nosuper_life", 32'(life_a), 0);
    chk("nosuper_gs", 32'(gs_a), 2);
`endif
    chk("super_score", 32'(score_a), m_score);
    sup = 0; pol = 0; box = '0;
    step();

    chk("round_bound", 32'(timeout_seen), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
